adc_serial_responder: RTL and testbench

//  Synthesizable model of the serial ADC at the far end of the ADC_Comm link.

---
 rtl/adc_comm_pkg.sv | 19 +
 rtl/sync_edge.sv | 32 +++
 rtl/adc_serial_responder.sv | 161 ++++++++++++++++
 tb/tb_adc_serial_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_comm_pkg.sv
// Shared definitions for the ADC_Comm link: default widths, frame length helper and
// the responder state type.
package adc_comm_pkg;

    localparam int unsigned ADC_DATA_W_DEFAULT     = 10;
    localparam int unsigned ADC_LEAD_ZEROS_DEFAULT = 3;

    function automatic int unsigned frame_bits(input int unsigned data_w,
                                               input int unsigned lead_zeros);
        return data_w + lead_zeros;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } adc_resp_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with single-cycle rise/fall pulses
// derived from the last synchronizer stage.
module sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Pulses are valid in the cycle after the last stage changes, so the consumer acts on
    // the edge STAGES+1 clocks after the pin moved.
    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Serial ADC responder: shifts a zero-led, MSB-first sample frame out on each ADC_CLK fall
// while chip select is low. Samples arrive from the fabric through a one-entry holding register.
module adc_serial_responder
    import adc_comm_pkg::*;
#(
    parameter int unsigned DATA_W      = ADC_DATA_W_DEFAULT,
    parameter int unsigned LEAD_ZEROS  = ADC_LEAD_ZEROS_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adc_clk,
    input  logic              adc_cs,
    output logic              data_out,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              underrun
);

    localparam int unsigned FRAME_BITS = frame_bits(DATA_W, LEAD_ZEROS);
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic cs_rise;
    logic cs_fall;
    logic sclk_fall;
    logic unused_sclk_rise;

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (adc_clk),
        .rise  (unused_sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (adc_cs),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    adc_resp_state_t        state_q, state_d;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   full_q, full_d;
    logic [DATA_W-1:0]      last_q, last_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic                   under_q, under_d;
    logic [DATA_W-1:0]      frame_sample;
    logic                   load;

    assign load = sample_valid & ~full_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        hold_d       = hold_q;
        full_d       = full_q;
        last_d       = last_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;
        under_d      = 1'b0;
        frame_sample = last_q;

        if (load) begin
            hold_d = sample_in;
            full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    // A load landing on the frame-start cycle bypasses the holding register.
                    if (full_q) begin
                        frame_sample = hold_q;
                        full_d       = 1'b0;
                    end else if (sample_valid) begin
                        frame_sample = sample_in;
                        full_d       = 1'b0;
                    end else begin
                        frame_sample = last_q;
                        under_d      = 1'b1;
                    end
                    shreg_d  = FRAME_BITS'(frame_sample);
                    last_d   = frame_sample;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == LAST_BIT) begin
                        done_d  = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            hold_q   <= '0;
            full_q   <= 1'b0;
            last_q   <= '0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            hold_q   <= hold_d;
            full_q   <= full_d;
            last_q   <= last_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            under_q  <= under_d;
        end
    end

    assign data_out     = (state_q == SHIFT) & shreg_q[FRAME_BITS-1];
    assign busy         = (state_q == SHIFT);
    assign sample_ready = ~full_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
    assign underrun     = under_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Self-checking bench: acts as the ADC_Comm master, reads frames back and compares them with a
// queue-based model of the holding register and last-sample replay.
module tb_adc_serial_responder;

    localparam int DW   = 10;
    localparam int FB   = 13;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          adc_clk = 1'b1;
    logic          adc_cs = 1'b1;
    logic          data_out;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          busy;
    logic          frame_done;
    logic          frame_abort;
    logic          underrun;

    adc_serial_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adc_clk      (adc_clk),
        .adc_cs       (adc_cs),
        .data_out     (data_out),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_abort = 0;
    int n_under = 0;

    always @(negedge clk) begin
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
        if (underrun)    n_under++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: at most one pending sample; a frame with nothing pending replays the last.
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] model_last = '0;

    task automatic model_load(input logic [DW-1:0] v);
        pend_q.push_back(v);
    endtask

    task automatic model_frame(output logic [DW-1:0] v, output bit und);
        if (pend_q.size() > 0) begin
            v = pend_q.pop_front();
            und = 1'b0;
        end else begin
            v = model_last;
            und = 1'b1;
        end
        model_last = v;
    endtask

    task automatic model_reset();
        pend_q.delete();
        model_last = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] v);
        int n;
        n = 0;
        while (!sample_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("load_ready_timeout", {31'd0, sample_ready}, 32'd1);
        sample_in = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        model_load(v);
    endtask

    // Master reads each bit while ADC_CLK is high, before driving the next fall.
    task automatic do_frame(input int half, output logic [FB-1:0] bits, output logic rdy_start);
        bits = '0;
        rdy_start = 1'b0;
        adc_cs = 1'b0;
        repeat (half) @(negedge clk);
        rdy_start = sample_ready;
        for (int i = 0; i < FB; i++) begin
            bits = {bits[FB-2:0], data_out};
            adc_clk = 1'b0;
            repeat (half) @(negedge clk);
            adc_clk = 1'b1;
            repeat (half) @(negedge clk);
        end
        adc_cs = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    typedef struct {
        bit            do_load;
        logic [DW-1:0] sample;
        logic [DW-1:0] exp_val;
        bit            exp_under;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [FB-1:0] bits;
        logic          rdy;
        logic [DW-1:0] mv;
        bit            mu;
        int            d0, a0, u0;

        vecs[0] = '{1'b1, 10'd50,   10'd50,   1'b0};
        vecs[1] = '{1'b1, 10'd1023, 10'd1023, 1'b0};
        vecs[2] = '{1'b1, 10'd0,    10'd0,    1'b0};
        vecs[3] = '{1'b1, 10'd7,    10'd7,    1'b0};
        vecs[4] = '{1'b0, 10'd0,    10'd7,    1'b1};
        vecs[5] = '{1'b1, 10'd341,  10'd341,  1'b0};

        #1;
        chk("rst_data_out", {31'd0, data_out}, 32'd0);
        chk("rst_ready", {31'd0, sample_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {29'd0, frame_done, frame_abort, underrun}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            d0 = n_done;
            u0 = n_under;
            if (vecs[i].do_load) load(vecs[i].sample);
            do_frame(HALF, bits, rdy);
            model_frame(mv, mu);
            chk("vec_model", {22'd0, mv}, {22'd0, vecs[i].exp_val});
            chk("vec_bits", {19'd0, bits}, {19'd0, 3'b000, vecs[i].exp_val});
            chk("vec_done", d0 + 1, n_done);
            chk("vec_under", n_under - u0, {31'd0, vecs[i].exp_under});
            chk("vec_ready_start", {31'd0, rdy}, 32'd1);
            chk("vec_busy_after", {31'd0, busy}, 32'd0);
        end

        // Abort after five falls; the remainder of 512 must not resurface.
        load(10'd512);
        d0 = n_done;
        a0 = n_abort;
        adc_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            adc_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            adc_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        chk("abort_busy_mid", {31'd0, busy}, 32'd1);
        adc_cs = 1'b1;
        repeat (HALF) @(negedge clk);
        model_frame(mv, mu);
        chk("abort_pulse", n_abort - a0, 32'd1);
        chk("abort_no_done", n_done - d0, 32'd0);
        chk("abort_data_out", {31'd0, data_out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        load(10'd300);
        do_frame(HALF, bits, rdy);
        model_frame(mv, mu);
        chk("after_abort_bits", {19'd0, bits}, {22'd0, mv});
        chk("after_abort_val", {22'd0, mv}, 32'd300);

        // Full holding register refuses a second sample.
        load(10'd100);
        chk("full_ready", {31'd0, sample_ready}, 32'd0);
        sample_in = 10'd200;
        sample_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("full_ready_held", {31'd0, sample_ready}, 32'd0);
        sample_valid = 1'b0;
        do_frame(HALF, bits, rdy);
        model_frame(mv, mu);
        chk("full_first", {19'd0, bits}, 32'd100);
        chk("full_ready_start", {31'd0, rdy}, 32'd1);
        u0 = n_under;
        do_frame(HALF, bits, rdy);
        model_frame(mv, mu);
        chk("full_200_dropped", {19'd0, bits}, 32'd100);
        chk("full_replay_under", n_under - u0, 32'd1);

        // Reset mid-frame with a refilled holding register.
        load(10'd55);
        adc_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        model_frame(mv, mu);
        for (int i = 0; i < 3; i++) begin
            adc_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            adc_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        load(10'd66);
        chk("pre_rst_ready", {31'd0, sample_ready}, 32'd0);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, sample_ready}, 32'd1);
        chk("mid_rst_data_out", {31'd0, data_out}, 32'd0);
        chk("mid_rst_pulses", {29'd0, frame_done, frame_abort, underrun}, 32'd0);
        adc_cs = 1'b1;
        adc_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        u0 = n_under;
        do_frame(HALF, bits, rdy);
        model_frame(mv, mu);
        chk("post_rst_bits", {19'd0, bits}, 32'd0);
        chk("post_rst_under", n_under - u0, 32'd1);

        // Randomized loads and ADC_CLK rates against the model.
        for (int i = 0; i < 14; i++) begin
            int h;
            h = $urandom_range(10, 5);
            u0 = n_under;
            d0 = n_done;
            if ($urandom_range(1, 0) == 1) load(10'($urandom));
            do_frame(h, bits, rdy);
            model_frame(mv, mu);
            chk("rnd_bits", {19'd0, bits}, {22'd0, mv});
            chk("rnd_under", n_under - u0, {31'd0, mu});
            chk("rnd_done", n_done - d0, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
